// File: rtl/rf_write_arbiter_if.sv
// Requester-side handshake bundle for the register-file write arbiter.
// Slice i of req_rd/req_data belongs to requester i.
interface rf_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_AW-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]   req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback sources,
// with a registered write stage and a pending-write scoreboard for the hazard unit.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                rf_write_enable,
  output logic [REG_AW-1:0]   rf_rd,
  output logic [XLEN-1:0]     rf_write_data,
  output logic [2:0]          grant_id,
  output logic [31:0]         busy
);

  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        gnt_idx;
  logic              xfer;
  logic [3:0]        cand;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_q;
  logic [2:0]        gid_q;
  logic [31:0]       busy_q, busy_d;

  // Search from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    xfer    = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!xfer && (4'(i) == cand) && bus.req_valid[i]) begin
          xfer    = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    sel_rd        = '0;
    sel_data      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == gnt_idx) begin
        bus.req_ready[i] = xfer;
        sel_rd           = bus.req_rd[i*REG_AW +: REG_AW];
        sel_data         = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

  // Set is applied after clear so a newly issued writer keeps its bit pending.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (sel_rd != '0)) begin
      busy_d[sel_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      gid_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      we_q   <= xfer && (sel_rd != '0);
      if (xfer) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
        gid_q  <= gnt_idx;
      end
    end
  end

  assign rf_write_enable = we_q;
  assign rf_rd           = rd_q;
  assign rf_write_data   = data_q;
  assign grant_id        = gid_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: arbitration order, write stage, scoreboard and
// reset behaviour, checked against hand-computed values.
module tb_rf_write_arbiter;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              rf_write_enable;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_write_data;
  logic [2:0]        grant_id;
  logic [31:0]       busy;

  int n_tests = 0;
  int n_fail  = 0;

  rf_write_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  rf_write_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .rf_write_enable (rf_write_enable),
    .rf_rd           (rf_rd),
    .rf_write_data   (rf_write_data),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [REG_AW-1:0] rd,
                         input logic [XLEN-1:0] d);
    bus.req_valid[i]               = v;
    bus.req_rd[i*REG_AW +: REG_AW] = rd;
    bus.req_data[i*XLEN +: XLEN]   = d;
  endtask

  // A requester stalled at one negedge must present the same rd/data at the next.
  logic [NUM_REQ-1:0]        prev_stall = '0;
  logic [NUM_REQ*REG_AW-1:0] prev_rd;
  logic [NUM_REQ*XLEN-1:0]   prev_data;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (prev_stall[i]) begin
          check("hold_rd", 64'(bus.req_rd[i*REG_AW +: REG_AW]), 64'(prev_rd[i*REG_AW +: REG_AW]));
          check("hold_data", 64'(bus.req_data[i*XLEN +: XLEN]), 64'(prev_data[i*XLEN +: XLEN]));
        end
      end
    end
    prev_stall <= bus.req_valid & ~bus.req_ready;
    prev_rd    <= bus.req_rd;
    prev_data  <= bus.req_data;
  end

  initial begin
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;

    // Reset state, and nothing registered while reset is held.
    #12;
    check("rst_we", 64'(rf_write_enable), 64'd0);
    check("rst_rd", 64'(rf_rd), 64'd0);
    check("rst_data", 64'(rf_write_data), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready_idle", 64'(bus.req_ready), 64'd0);
    set_req(0, 1'b1, 5'd5, 32'hCAFE_0001);
    issue_valid = 1'b1;
    issue_rd    = 5'd6;
    #1;
    check("rst_ready_comb", 64'(bus.req_ready), 64'b001);
    tick();
    check("rst_no_we", 64'(rf_write_enable), 64'd0);
    check("rst_no_busy", 64'(busy), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    issue_rd    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single requester, one-cycle latency, single-cycle pulse.
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_ready", 64'(bus.req_ready), 64'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    check("t1_we", 64'(rf_write_enable), 64'd1);
    check("t1_rd", 64'(rf_rd), 64'd5);
    check("t1_data", 64'(rf_write_data), 64'hDEAD_BEEF);
    check("t1_gid", 64'(grant_id), 64'd0);
    tick();
    check("t1_we_low", 64'(rf_write_enable), 64'd0);
    check("t1_rd_hold", 64'(rf_rd), 64'd5);
    check("t1_data_hold", 64'(rf_write_data), 64'hDEAD_BEEF);

    // x0 write from requester 2 (pointer is 1): accepted, no strobe, no busy bit.
    set_req(2, 1'b1, 5'd0, 32'h1234);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    @(negedge clk);
    check("x0_ready", 64'(bus.req_ready), 64'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    check("x0_we", 64'(rf_write_enable), 64'd0);
    check("x0_gid", 64'(grant_id), 64'd2);
    check("x0_rd", 64'(rf_rd), 64'd0);
    check("x0_data", 64'(rf_write_data), 64'h1234);
    check("x0_busy", 64'(busy), 64'd0);

    // Round-robin with all requesters held valid; pointer now 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b1, 5'(10 + i), 32'(32'hA0 + i));
    end
    for (int c = 0; c < 6; c++) begin
      logic [2:0] e;
      e = 3'(1 << (c % 3));
      @(negedge clk);
      check("rr_ready", 64'(bus.req_ready), 64'(e));
      if (c > 0) begin
        check("rr_we", 64'(rf_write_enable), 64'd1);
        check("rr_gid", 64'(grant_id), 64'((c - 1) % 3));
        check("rr_rd", 64'(rf_rd), 64'(10 + (c - 1) % 3));
      end
      tick();
    end
    bus.req_valid = '0;
    check("rr_last_we", 64'(rf_write_enable), 64'd1);
    check("rr_last_gid", 64'(grant_id), 64'd2);
    check("rr_last_data", 64'(rf_write_data), 64'hA2);
    tick();
    check("rr_we_low", 64'(rf_write_enable), 64'd0);

    // Scoreboard set, then clear on the write by requester 1.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("sb_set", 64'(busy), 64'(32'd1 << 7));
    set_req(1, 1'b1, 5'd7, 32'h7777);
    @(negedge clk);
    check("sb_ready", 64'(bus.req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    check("sb_we", 64'(rf_write_enable), 64'd1);
    check("sb_rd", 64'(rf_rd), 64'd7);
    check("sb_gid", 64'(grant_id), 64'd1);
    check("sb_clear", 64'(busy), 64'd0);

    // Set/clear collision on x9 (set wins), then set x3 while clearing x9.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    check("col_pre", 64'(busy), 64'(32'd1 << 9));
    set_req(0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    check("col_ready", 64'(bus.req_ready), 64'b001);
    tick();
    check("col_we", 64'(rf_write_enable), 64'd1);
    check("col_data", 64'(rf_write_data), 64'h99);
    check("col_busy", 64'(busy), 64'(32'd1 << 9));
    issue_rd = 5'd3;
    set_req(0, 1'b1, 5'd9, 32'h98);
    tick();
    issue_valid = 1'b0;
    set_req(0, 1'b0, 5'd0, 32'd0);
    check("diff_busy", 64'(busy), 64'(32'd1 << 3));
    check("diff_data", 64'(rf_write_data), 64'h98);

    // Async reset mid-stream (pointer is 1 here).
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b1, 5'(20 + i), 32'(i + 1));
    end
    @(negedge clk);
    check("ar_ready", 64'(bus.req_ready), 64'b010);
    tick();
    check("ar_we_pre", 64'(rf_write_enable), 64'd1);
    check("ar_gid_pre", 64'(grant_id), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we", 64'(rf_write_enable), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_rd", 64'(rf_rd), 64'd0);
    check("ar_gid", 64'(grant_id), 64'd0);
    tick();
    check("ar_held_we", 64'(rf_write_enable), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_first_ready", 64'(bus.req_ready), 64'b001);
    tick();
    check("ar_first_we", 64'(rf_write_enable), 64'd1);
    check("ar_first_gid", 64'(grant_id), 64'd0);
    check("ar_first_rd", 64'(rf_rd), 64'd20);
    bus.req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between several writeback sources: pipeline WB, multi-cycle mul/div unit, and CSR/debug write path.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the granted write into the register-file write port.
- Keeps a 32-bit pending-write scoreboard that the hazard unit uses to stall reads of registers whose writes are still outstanding.

Parameters:
NUM_REQ, 3, number of write requesters (2..8); index 0 is pipeline WB
XLEN, 32, data width of a register write
REG_AW, 5, register address width (32 architectural registers)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a write pending
req_rd  input  NUM_REQ*REG_AW  destination register of requester i (slice i)
req_data  input  NUM_REQ*XLEN  write data of requester i (slice i)
req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i]
issue_valid  input  1  decode issued an instruction that will write issue_rd
issue_rd  input  REG_AW  destination register being issued
rf_write_enable  output  1  write strobe to register file
rf_rd  output  REG_AW  register-file write address
rf_write_data  output  XLEN  register-file write data
grant_id  output  3  index of the requester whose write is on rf_* this cycle
busy  output  32  scoreboard; bit n = write to xn pending

Behaviour:
- Reset (async, rst_n=0):
  - rf_write_enable=0, rf_rd=0, rf_write_data=0, grant_id=0.
  - busy=0.
  - Round-robin pointer = 0.
  - req_ready follows the combinational rule, but nothing is registered while reset is asserted.
  - Reset mid-transaction discards any registered write; it is not replayed.
- Arbitration (combinational, each cycle):
  - Search starts at the pointer and proceeds upward with wrap, modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other req_ready bits are 0.
  - No valid requests: req_ready=0.
  - req_ready never depends on req_data or req_rd.
- Pointer update (posedge):
  - After a transfer from requester g, pointer <= (g+1) mod NUM_REQ.
  - No transfer: pointer is unchanged.
- Output stage (posedge), 1-cycle latency:
  - On a transfer from g: rf_write_enable <= (rd_g != 0), rf_rd <= rd_g, rf_write_data <= data_g, grant_id <= g.
  - No transfer: rf_write_enable <= 0; rf_rd, rf_write_data and grant_id hold their previous values.
  - rf_write_enable is a single-cycle pulse per accepted write.
  - Throughput: one write per cycle, back-to-back.
- The register file samples on negedge, so rf_* are stable for a half cycle before use.
- No backpressure from the register file; the arbiter never stalls an accepted write.
- Writes to x0:
  - Accepted normally (handshake completes, pointer advances).
  - rf_write_enable stays 0, and busy is unaffected.
- Scoreboard (posedge):
  - Set: issue_valid=1 and issue_rd!=0 sets busy[issue_rd].
  - Clear: on a transfer with rd!=0, busy[rd] is cleared in the same edge that registers the write onto rf_*.
  - Set and clear of the same register in one cycle: set wins. A newer writer is pending, and the bit stays 1.
  - Set and clear of different registers in one cycle: both take effect.
  - busy[0] is always 0.
  - A clear of a non-busy bit has no effect and raises no error.
- A requester holding req_valid without ready must keep req_rd and req_data stable.
  - The bench asserts this; the RTL does not check it.
- All requesters are equal under round-robin, so each requester is guaranteed a grant within NUM_REQ cycles of raising valid.

Test Plan:
1. Reset, then a single requester: req_valid=3'b001, rd=5, data=0xDEADBEEF for one cycle.
   -> req_ready=001 that cycle; next cycle rf_write_enable=1, rf_rd=5, rf_write_data=0xDEADBEEF, grant_id=0; the cycle after, rf_write_enable=0.
2. Round-robin fairness: req_valid=111 held for 6 cycles.
   -> grant order 0,1,2,0,1,2; six consecutive rf_write_enable pulses; grant_id follows the same order one cycle later.
3. Scoreboard: issue rd=7.
   -> busy[7]=1 next cycle. Requester 1 then writes rd=7 -> busy[7]=0 in the same cycle rf_write_enable=1 with rf_rd=7.
4. Set/clear collision: busy[9]=1, then in one cycle issue_valid with issue_rd=9 and a transfer to rd=9.
   -> busy[9] remains 1 and the write is performed.
5. x0 handling: requester 2 writes rd=0, data=0x1234, and issue_valid with issue_rd=0.
   -> handshake completes, pointer moves to 0, rf_write_enable stays 0, busy stays 0.
6. Async reset mid-stream: req_valid=111 streaming, then rst_n=0 between edges.
   -> rf_write_enable=0 and busy=0 immediately; after release, the first grant goes to requester 0.
